// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU on grant, and the result returns one cycle later with a done pulse.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [CMD_W-1:0] cmd0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [CMD_W-1:0] cmd1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [CMD_W-1:0] alu_command,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic             gnt_id_reg, gnt_id_next;
    logic             last_grant_reg, last_grant_next;
    logic [1:0]       done_reg, done_next;
    logic [CMD_W-1:0] alu_command_reg, alu_command_next;
    logic [WIDTH-1:0] alu_a_reg, alu_a_next;
    logic [WIDTH-1:0] alu_b_reg, alu_b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             grant_port;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            gnt_id_reg      <= 1'b0;
            last_grant_reg  <= 1'b1;   // port 0 wins the first tie
            done_reg        <= 2'b00;
            alu_command_reg <= '0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            result_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            gnt_id_reg      <= gnt_id_next;
            last_grant_reg  <= last_grant_next;
            done_reg        <= done_next;
            alu_command_reg <= alu_command_next;
            alu_a_reg       <= alu_a_next;
            alu_b_reg       <= alu_b_next;
            result_reg      <= result_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        gnt_id_next      = gnt_id_reg;
        last_grant_next  = last_grant_reg;
        alu_command_next = alu_command_reg;
        alu_a_next       = alu_a_reg;
        alu_b_next       = alu_b_reg;
        result_next      = result_reg;
        grant_port       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    grant_port       = (req0 && req1) ? ~last_grant_reg : req1;
                    gnt_id_next      = grant_port;
                    last_grant_next  = grant_port;
                    alu_command_next = grant_port ? cmd1 : cmd0;
                    alu_a_next       = grant_port ? a1 : a0;
                    alu_b_next       = grant_port ? b1 : b0;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                result_next = alu_result;
                state_next  = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done is raised only for the granted port during the EXEC->RESP transfer
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign done_next[gi] = (state_reg == EXEC) && (gnt_id_reg == 1'(gi));
        end
    endgenerate

    assign done0       = done_reg[0];
    assign done1       = done_reg[1];
    assign result      = result_reg;
    assign busy        = (state_reg == EXEC) || (state_reg == RESP);
    assign alu_command = alu_command_reg;
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;

endmodule
